// File: rtl/bus_arbiter_if.sv
// Bus arbiter handshake bundle: DMA request/grant plus CPU access qualifiers.
// The master modport is the arbiter side; the slave modport is the CPU/DMA side.
interface bus_arbiter_if;
  logic       br;
  logic       cpu_mem_busy;
  logic       dma_use_bus;
  logic       bg;
  logic       cpu_bus_ok;
  logic [7:0] grant_count;
  logic       proto_err;
  logic       wd_error;

  modport master (
    input  br, cpu_mem_busy, dma_use_bus,
    output bg, cpu_bus_ok, grant_count, proto_err, wd_error
  );

  modport slave (
    output br, cpu_mem_busy, dma_use_bus,
    input  bg, cpu_bus_ok, grant_count, proto_err, wd_error
  );
endinterface

// File: rtl/bus_arbiter.sv
// Single-master DMA/CPU bus arbiter.
// Optional grant watchdog built only when BUS_WATCHDOG_EN is defined.
//
// state    | meaning
// CPU_OWN  | CPU owns the bus, DMA request evaluated here
// DRAIN    | DMA requested, waiting for the CPU access in flight to finish
// DMA_OWN  | DMA granted (bg=1)
// HANDBACK | one-cycle turnaround after DMA releases
module bus_arbiter #(
  parameter int WD_LIMIT = 64
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.master bus
);

  localparam logic [1:0] CPU_OWN  = 2'd0;
  localparam logic [1:0] DRAIN    = 2'd1;
  localparam logic [1:0] DMA_OWN  = 2'd2;
  localparam logic [1:0] HANDBACK = 2'd3;

  logic [1:0] state_q, state_d;
  logic       bg_q, bg_d;
  logic [7:0] grant_count_q, grant_count_d;
  logic       proto_err_q, proto_err_d;
  logic       grant_entry;

  // Next-state decode; cpu_mem_busy is ignored once the DMA owns the bus.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CPU_OWN: begin
        if (bus.br && !bus.cpu_mem_busy) state_d = DMA_OWN;
        else if (bus.br)                 state_d = DRAIN;
      end
      DRAIN: begin
        if (!bus.br)                   state_d = CPU_OWN;
        else if (!bus.cpu_mem_busy)    state_d = DMA_OWN;
      end
      DMA_OWN: begin
        if (!bus.br) state_d = HANDBACK;
      end
      HANDBACK: state_d = CPU_OWN;
      default:  state_d = CPU_OWN;
    endcase
  end

  // Grant, grant counter and protocol-error flag derived from the transition.
  always_comb begin
    grant_entry   = (state_q != DMA_OWN) && (state_d == DMA_OWN);
    bg_d          = (state_d == DMA_OWN);
    grant_count_d = grant_entry ? grant_count_q + 8'd1 : grant_count_q;
    proto_err_d   = proto_err_q | (bus.dma_use_bus & ~bg_q);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= CPU_OWN;
      bg_q          <= 1'b0;
      grant_count_q <= 8'd0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      bg_q          <= bg_d;
      grant_count_q <= grant_count_d;
      proto_err_q   <= proto_err_d;
    end
  end

  assign bus.bg          = bg_q;
  assign bus.cpu_bus_ok  = (state_q == CPU_OWN) && !bus.br;
  assign bus.grant_count = grant_count_q;
  assign bus.proto_err   = proto_err_q;

`ifdef BUS_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_LIMIT) + 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WD_LIMIT);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            wd_error_q, wd_error_d;

  // Watchdog counts DMA_OWN cycles, saturating at the limit; it only flags.
  always_comb begin
    wd_cnt_d   = wd_cnt_q;
    wd_error_d = wd_error_q;
    if (grant_entry)
      wd_cnt_d = '0;
    else if (state_q == DMA_OWN && wd_cnt_q != WD_MAX)
      wd_cnt_d = wd_cnt_q + 1'b1;
    if (wd_cnt_d == WD_MAX)
      wd_error_d = 1'b1;
  end

  // Watchdog registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_q   <= '0;
      wd_error_q <= 1'b0;
    end else begin
      wd_cnt_q   <= wd_cnt_d;
      wd_error_q <= wd_error_d;
    end
  end

  assign bus.wd_error = wd_error_q;
`else
  assign bus.wd_error = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter (WD_LIMIT=16). Inputs change 1 time unit
// after the rising edge; outputs are checked at that same point.
module tb_bus_arbiter;

`ifdef BUS_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  bus_arbiter_if bus_i ();

  bus_arbiter #(.WD_LIMIT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_i.br = 1'b0; bus_i.cpu_mem_busy = 1'b0; bus_i.dma_use_bus = 1'b0;
    tick(); tick();
    n_checks++; if (bus_i.bg !== 1'b0) begin n_fail++; $display("FAIL reset_bg got=%b exp=0", bus_i.bg); end
    n_checks++; if (bus_i.grant_count !== 8'd0) begin n_fail++; $display("FAIL reset_grant got=%0d exp=0", bus_i.grant_count); end
    n_checks++; if (bus_i.proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_proto got=%b exp=0", bus_i.proto_err); end
    n_checks++; if (bus_i.wd_error !== 1'b0) begin n_fail++; $display("FAIL reset_wd got=%b exp=0", bus_i.wd_error); end
    n_checks++; if (bus_i.cpu_bus_ok !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_ok got=%b exp=1", bus_i.cpu_bus_ok); end
    reset = 1'b0;
    tick();
    n_checks++; if (bus_i.bg !== 1'b0) begin n_fail++; $display("FAIL idle_bg got=%b exp=0", bus_i.bg); end
  endtask

  task automatic test_basic_grant();
    bus_i.br = 1'b1;
    #1;
    n_checks++; if (bus_i.cpu_bus_ok !== 1'b0) begin n_fail++; $display("FAIL req_cpu_ok got=%b exp=0", bus_i.cpu_bus_ok); end
    n_checks++; if (bus_i.bg !== 1'b0) begin n_fail++; $display("FAIL pre_grant_bg got=%b exp=0", bus_i.bg); end
    tick();
    n_checks++; if (bus_i.bg !== 1'b1) begin n_fail++; $display("FAIL grant_bg got=%b exp=1", bus_i.bg); end
    n_checks++; if (bus_i.grant_count !== 8'd1) begin n_fail++; $display("FAIL grant_count1 got=%0d exp=1", bus_i.grant_count); end
    n_checks++; if (bus_i.cpu_bus_ok !== 1'b0) begin n_fail++; $display("FAIL grant_cpu_ok got=%b exp=0", bus_i.cpu_bus_ok); end
    bus_i.br = 1'b0;
    tick();
    n_checks++; if (bus_i.bg !== 1'b0) begin n_fail++; $display("FAIL handback_bg got=%b exp=0", bus_i.bg); end
    n_checks++; if (bus_i.cpu_bus_ok !== 1'b0) begin n_fail++; $display("FAIL handback_cpu_ok got=%b exp=0", bus_i.cpu_bus_ok); end
    tick();
    n_checks++; if (bus_i.cpu_bus_ok !== 1'b1) begin n_fail++; $display("FAIL after_handback_cpu_ok got=%b exp=1", bus_i.cpu_bus_ok); end
  endtask

  task automatic test_drain();
    bus_i.br = 1'b1; bus_i.cpu_mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus_i.bg !== 1'b0) begin n_fail++; $display("FAIL drain_bg cyc=%0d got=%b exp=0", i, bus_i.bg); end
      n_checks++; if (bus_i.cpu_bus_ok !== 1'b0) begin n_fail++; $display("FAIL drain_cpu_ok cyc=%0d got=%b exp=0", i, bus_i.cpu_bus_ok); end
    end
    bus_i.cpu_mem_busy = 1'b0;
    tick();
    n_checks++; if (bus_i.bg !== 1'b1) begin n_fail++; $display("FAIL drain_grant_bg got=%b exp=1", bus_i.bg); end
    n_checks++; if (bus_i.grant_count !== 8'd2) begin n_fail++; $display("FAIL drain_grant_count got=%0d exp=2", bus_i.grant_count); end
    bus_i.br = 1'b0;
    tick(); tick();
  endtask

  task automatic test_withdraw();
    bus_i.br = 1'b1; bus_i.cpu_mem_busy = 1'b1;
    tick();
    bus_i.br = 1'b0;
    tick();
    n_checks++; if (bus_i.cpu_bus_ok !== 1'b1) begin n_fail++; $display("FAIL withdraw_cpu_ok got=%b exp=1", bus_i.cpu_bus_ok); end
    n_checks++; if (bus_i.bg !== 1'b0) begin n_fail++; $display("FAIL withdraw_bg got=%b exp=0", bus_i.bg); end
    n_checks++; if (bus_i.grant_count !== 8'd2) begin n_fail++; $display("FAIL withdraw_grant got=%0d exp=2", bus_i.grant_count); end
    bus_i.cpu_mem_busy = 1'b0;
    tick();
  endtask

  task automatic test_hold_release();
    bus_i.br = 1'b1;
    tick();
    n_checks++; if (bus_i.grant_count !== 8'd3) begin n_fail++; $display("FAIL hold_grant got=%0d exp=3", bus_i.grant_count); end
    bus_i.cpu_mem_busy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++; if (bus_i.bg !== 1'b1) begin n_fail++; $display("FAIL hold_bg cyc=%0d got=%b exp=1", i, bus_i.bg); end
    end
    bus_i.cpu_mem_busy = 1'b0; bus_i.br = 1'b0;
    tick();
    n_checks++; if (bus_i.bg !== 1'b0) begin n_fail++; $display("FAIL release_bg got=%b exp=0", bus_i.bg); end
    n_checks++; if (bus_i.cpu_bus_ok !== 1'b0) begin n_fail++; $display("FAIL release_handback_ok got=%b exp=0", bus_i.cpu_bus_ok); end
    tick();
    n_checks++; if (bus_i.cpu_bus_ok !== 1'b1) begin n_fail++; $display("FAIL release_cpu_ok got=%b exp=1", bus_i.cpu_bus_ok); end
  endtask

  task automatic test_back_to_back();
    bus_i.br = 1'b1;
    tick();
    n_checks++; if (bus_i.grant_count !== 8'd4) begin n_fail++; $display("FAIL b2b_grant1 got=%0d exp=4", bus_i.grant_count); end
    bus_i.br = 1'b0;
    tick();
    bus_i.br = 1'b1;
    tick();
    n_checks++; if (bus_i.bg !== 1'b0) begin n_fail++; $display("FAIL b2b_cpu_own_bg got=%b exp=0", bus_i.bg); end
    tick();
    n_checks++; if (bus_i.bg !== 1'b1) begin n_fail++; $display("FAIL b2b_regrant_bg got=%b exp=1", bus_i.bg); end
    n_checks++; if (bus_i.grant_count !== 8'd5) begin n_fail++; $display("FAIL b2b_grant2 got=%0d exp=5", bus_i.grant_count); end
    bus_i.br = 1'b0;
    tick(); tick();
  endtask

  task automatic test_proto();
    bus_i.br = 1'b1;
    tick();
    bus_i.dma_use_bus = 1'b1;
    tick();
    n_checks++; if (bus_i.proto_err !== 1'b0) begin n_fail++; $display("FAIL proto_granted got=%b exp=0", bus_i.proto_err); end
    bus_i.br = 1'b0; bus_i.dma_use_bus = 1'b0;
    tick();
    bus_i.dma_use_bus = 1'b1;
    tick();
    n_checks++; if (bus_i.proto_err !== 1'b1) begin n_fail++; $display("FAIL proto_set got=%b exp=1", bus_i.proto_err); end
    bus_i.dma_use_bus = 1'b0;
    tick(); tick();
    n_checks++; if (bus_i.proto_err !== 1'b1) begin n_fail++; $display("FAIL proto_sticky got=%b exp=1", bus_i.proto_err); end
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    #1;
    n_checks++; if (bus_i.proto_err !== 1'b0) begin n_fail++; $display("FAIL proto_reset got=%b exp=0", bus_i.proto_err); end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      bus_i.br = 1'b1; tick();
      bus_i.br = 1'b0; tick(); tick();
      if (i == 254) begin
        n_checks++; if (bus_i.grant_count !== 8'd255) begin n_fail++; $display("FAIL wrap_255 got=%0d exp=255", bus_i.grant_count); end
      end
    end
    n_checks++; if (bus_i.grant_count !== 8'd0) begin n_fail++; $display("FAIL wrap_0 got=%0d exp=0", bus_i.grant_count); end
  endtask

  task automatic test_watchdog();
    reset = 1'b1; tick(); reset = 1'b0;
    bus_i.br = 1'b1;
    tick();
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 15) begin
        n_checks++; if (bus_i.wd_error !== 1'b0) begin n_fail++; $display("FAIL wd_early got=%b exp=0", bus_i.wd_error); end
      end
      if (k == 16) begin
        n_checks++; if (bus_i.wd_error !== WD_ON) begin n_fail++; $display("FAIL wd_limit got=%b exp=%b", bus_i.wd_error, WD_ON); end
      end
    end
    n_checks++; if (bus_i.bg !== 1'b1) begin n_fail++; $display("FAIL wd_bg_held got=%b exp=1", bus_i.bg); end
    n_checks++; if (bus_i.wd_error !== WD_ON) begin n_fail++; $display("FAIL wd_sticky got=%b exp=%b", bus_i.wd_error, WD_ON); end
    bus_i.br = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    bus_i.br = 1'b1;
    tick();
    n_checks++; if (bus_i.bg !== 1'b1) begin n_fail++; $display("FAIL mid_pre_bg got=%b exp=1", bus_i.bg); end
    reset = 1'b1;
    #1;
    n_checks++; if (bus_i.bg !== 1'b0) begin n_fail++; $display("FAIL mid_async_bg got=%b exp=0", bus_i.bg); end
    n_checks++; if (bus_i.grant_count !== 8'd0) begin n_fail++; $display("FAIL mid_async_grant got=%0d exp=0", bus_i.grant_count); end
    n_checks++; if (bus_i.wd_error !== 1'b0) begin n_fail++; $display("FAIL mid_async_wd got=%b exp=0", bus_i.wd_error); end
    tick();
    reset = 1'b0;
    tick();
    n_checks++; if (bus_i.bg !== 1'b1) begin n_fail++; $display("FAIL mid_regrant_bg got=%b exp=1", bus_i.bg); end
    n_checks++; if (bus_i.grant_count !== 8'd1) begin n_fail++; $display("FAIL mid_regrant_count got=%0d exp=1", bus_i.grant_count); end
    bus_i.br = 1'b0;
    tick(); tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic_grant();
    test_drain();
    test_withdraw();
    test_hold_release();
    test_back_to_back();
    test_proto();
    test_wrap();
    test_watchdog();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: WD_LIMIT, 64, DMA_OWN cycles before watchdog flags (only used with BUS_WATCHDOG_EN).
REQ-002 clk  input  1  single system clock; all state updates on posedge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 br  input  1  bus request from the DMA engine; level, held until the DMA finishes.
REQ-005 cpu_mem_busy  input  1  CPU has a memory access in flight; the bus cannot change hands.
REQ-006 dma_use_bus  input  1  DMA is driving address/data lines.
REQ-007 bg  output  1  bus grant to the DMA engine; registered.
REQ-008 cpu_bus_ok  output  1  CPU may start a new memory access this cycle; combinational.
REQ-009 grant_count  output  8  number of grants issued since reset; wraps.
REQ-010 proto_err  output  1  sticky: DMA drove the bus without a grant.
REQ-011 wd_error  output  1  sticky: grant held for WD_LIMIT cycles or more.

Function
REQ-012 The FSM shall have four states: CPU_OWN=0, DRAIN=1, DMA_OWN=2, HANDBACK=3.
REQ-013 In CPU_OWN: br=1 and cpu_mem_busy=0 -> DMA_OWN; br=1 and cpu_mem_busy=1 -> DRAIN; else stay.
REQ-014 In DRAIN: cpu_mem_busy=0 -> DMA_OWN; else stay; br dropping in DRAIN -> CPU_OWN (request withdrawn, no grant).
REQ-015 In DMA_OWN: br=0 -> HANDBACK; else stay.
REQ-016 HANDBACK shall last exactly one cycle, then go to CPU_OWN; a br=1 seen in HANDBACK is evaluated only in CPU_OWN.
REQ-017 bg shall be 1 iff state==DMA_OWN, so bg rises one cycle after the qualifying edge and falls one cycle after br=0 is sampled.
REQ-018 cpu_bus_ok shall be (state==CPU_OWN) AND NOT br; it is 0 in DRAIN, DMA_OWN and HANDBACK.
REQ-019 grant_count shall increment by 1 on every transition into DMA_OWN; 255 wraps to 0.
REQ-020 proto_err shall set on any posedge where dma_use_bus=1 and bg=0; it clears only on reset.
REQ-021 cpu_mem_busy=1 sampled in DMA_OWN or HANDBACK shall not change the FSM (CPU protocol violation, ignored).

Reset
REQ-022 reset=1 shall immediately force state=CPU_OWN, bg=0, grant_count=0, proto_err=0, wd_error=0, watchdog counter=0.
REQ-023 Reset asserted during DMA_OWN shall drop bg asynchronously, with no HANDBACK cycle.
REQ-024 After reset release, the first transition shall be evaluated at the next posedge.

Configuration
REQ-025 With BUS_WATCHDOG_EN defined: a counter of width clog2(WD_LIMIT)+1 clears on entry to DMA_OWN, increments each DMA_OWN cycle, and sets wd_error sticky when it reaches WD_LIMIT; it saturates there, and bg is not forced low.
REQ-026 Without BUS_WATCHDOG_EN: no counter logic is built and wd_error is tied to 0.

Verification
REQ-027 reset, then br=1 with cpu_mem_busy=0 at edge N -> bg=1 after edge N, grant_count=1, cpu_bus_ok=0.
REQ-028 br=1 while cpu_mem_busy=1 for 3 cycles -> DRAIN for 3 cycles with bg=0; bg=1 the cycle after cpu_mem_busy falls.
REQ-029 grant held for 12 cycles, then br=0 -> bg=0 next cycle, one HANDBACK cycle with cpu_bus_ok=0, then cpu_bus_ok=1.
REQ-030 256 complete grant/release cycles -> grant_count returns to 0; dma_use_bus=1 while bg=0 -> proto_err=1 until reset.
REQ-031 BUS_WATCHDOG_EN defined and WD_LIMIT=16, br held 20 cycles -> wd_error=1 after the 16th DMA_OWN cycle and bg stays 1; without the macro -> wd_error=0.
REQ-032 reset pulse mid-DMA_OWN -> bg=0 within the same cycle and grant_count=0; br still 1 after release -> new grant, grant_count=1.
